// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsuState_t : controller state encoding (IDLE/REQ/WAIT/DONE)
//   F3_*       : RV32I load/store funct3 encodings (size + sign)
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsuState_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit and memory.
//   master : LSU side  (drives req/we/addr/be/wdata, receives gnt/rvalid/rdata/err)
//   slave  : memory side
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3/addrLo/isStore/storeData -> byteEn, wdata, misalign (request side, live)
//   rspFunct3/rspAddrLo/rdata       -> loadData (response side, latched request info)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic        isStore,
    input  logic [31:0] storeData,
    output logic [3:0]  byteEn,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [2:0]  rspFunct3,
    input  logic [1:0]  rspAddrLo,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);
    logic        illegal;
    logic        unaligned;
    logic [31:0] lane;

    always_comb begin
        byteEn    = '0;
        wdata     = storeData;
        unaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byteEn = 4'b0001 << addrLo;
                wdata  = {4{storeData[7:0]}};
            end
            2'b01: begin
                byteEn    = 4'b0011 << addrLo;
                wdata     = {2{storeData[15:0]}};
                unaligned = addrLo[0];
            end
            2'b10: begin
                byteEn    = 4'b1111;
                unaligned = (addrLo != 2'b00);
            end
            default: byteEn = '0;
        endcase

        // Stores only have unsigned-free encodings B/H/W; loads reject 011/110/111.
        if (isStore)
            illegal = funct3[2] || (funct3[1:0] == 2'b11);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);

        misalign = illegal || unaligned;
    end

    always_comb begin
        lane = rdata >> {rspAddrLo, 3'b000};
        case (rspFunct3)
            F3_B:    loadData = {{24{lane[7]}}, lane[7:0]};
            F3_H:    loadData = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   loadData = {24'b0, lane[7:0]};
            F3_HU:   loadData = {16'b0, lane[15:0]};
            default: loadData = lane;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine.
//   clk, rst (async, active-low)
//   MemReadM/MemWriteM/funct3M/ALUResultM/WriteDataM : EX/MEM request
//   ReadDataM : extended load data to MEM/WB (held between loads)
//   StallM    : pipeline freeze while a transfer is outstanding
//   MisalignM : 1-cycle pulse for misaligned/illegal access (no bus transfer)
//   BusErrM   : 1-cycle pulse in DONE for bus error or timeout
//   bus       : data bus master (req/gnt/rvalid handshake)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    output logic            BusErrM,
    lsu_if.master           bus
);
    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Abort on the edge where the counter would reach TIMEOUT_CYC-1, so the
    // whole transfer (IDLE cycle included) stalls exactly TIMEOUT_CYC cycles.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 2);

    lsuState_t   state, nextState;
    logic [CW-1:0] cnt;
    logic [2:0]  rspFunct3;
    logic [1:0]  rspOff;
    logic        rspLoad;
    logic        stallC, misC, respond, abort, timeoutHit, leaveIdle;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata, loadData;
    logic        alignMis;

    lsu_align uAlign (
        .funct3    (funct3M),
        .addrLo    (ALUResultM[1:0]),
        .isStore   (MemWriteM),
        .storeData (WriteDataM),
        .byteEn    (alignBe),
        .wdata     (alignWdata),
        .misalign  (alignMis),
        .rspFunct3 (rspFunct3),
        .rspAddrLo (rspOff),
        .rdata     (bus.bus_rdata),
        .loadData  (loadData)
    );

    assign timeoutHit = (cnt == TO_LAST);

    always_comb begin
        nextState = state;
        stallC    = 1'b0;
        misC      = 1'b0;
        respond   = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MemReadM || MemWriteM) begin
                    if (alignMis) begin
                        misC = 1'b1;
                    end else begin
                        stallC    = 1'b1;
                        nextState = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stallC = 1'b1;
                if (bus.bus_gnt && bus.bus_rvalid) begin
                    respond   = 1'b1;
                    nextState = ST_DONE;
                end else if (timeoutHit) begin
                    abort     = 1'b1;
                    nextState = ST_DONE;
                end else if (bus.bus_gnt) begin
                    nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stallC = 1'b1;
                if (bus.bus_rvalid) begin
                    respond   = 1'b1;
                    nextState = ST_DONE;
                end else if (timeoutHit) begin
                    abort     = 1'b1;
                    nextState = ST_DONE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Gated so that outputs read 0 while reset is held even with a request pending.
    assign StallM    = rst && stallC;
    assign MisalignM = rst && misC;
    assign leaveIdle = (state == ST_IDLE) && (nextState == ST_REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rspFunct3     <= '0;
            rspOff        <= '0;
            rspLoad       <= 1'b0;
            ReadDataM     <= '0;
            BusErrM       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            state   <= nextState;
            BusErrM <= abort || (respond && bus.bus_err);

            if (leaveIdle) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= MemWriteM;
                bus.bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus.bus_be    <= alignBe;
                bus.bus_wdata <= alignWdata;
                rspFunct3     <= funct3M;
                rspOff        <= ALUResultM[1:0];
                rspLoad       <= !MemWriteM;
                cnt           <= '0;
            end else if (state == ST_REQ || state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end

            if (state == ST_REQ && nextState != ST_REQ)
                bus.bus_req <= 1'b0;

            if (misC || abort || (respond && bus.bus_err))
                ReadDataM <= '0;
            else if (respond && rspLoad)
                ReadDataM <= loadData;
        end
    end
endmodule
